// File: rtl/wb_regfile_unit.sv
// Writeback stage: selects load/ALU data, commits to the integer or float bank, serves two
// bypassed read ports, and publishes a registered record of the last commit plus a counter.
module wb_regfile_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_reg_write,
    input  logic             wb_freg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_mem_to_reg,
    input  logic [XLEN-1:0]  wb_mem_data,
    input  logic [XLEN-1:0]  wb_alu_result,
    input  logic [4:0]       rs1_addr,
    input  logic             rs1_float,
    input  logic [4:0]       rs2_addr,
    input  logic             rs2_float,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  wb_data,
    output logic             fwd_valid,
    output logic             fwd_float,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] commit_cnt
);

    logic [XLEN-1:0]  int_bank_q [NREGS];
    logic [XLEN-1:0]  fp_bank_q  [NREGS];
    logic             int_we;
    logic             fp_we;
    logic             fwd_valid_q;
    logic             fwd_float_q;
    logic [4:0]       fwd_rd_q;
    logic [XLEN-1:0]  fwd_data_q;
    logic [CNT_W-1:0] cnt_q;

    // Float enable wins when both are raised; integer writes to x0 are dropped entirely.
    always_comb begin
        wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
        fp_we   = wb_freg_write;
        int_we  = wb_reg_write & ~wb_freg_write & (wb_rd != 5'd0);
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_float) begin
            rs1_data = fp_bank_q[rs1_addr];
        end else if (rs1_addr != 5'd0) begin
            rs1_data = int_bank_q[rs1_addr];
        end
        if ((rs1_addr == wb_rd) && ((fp_we && rs1_float) || (int_we && !rs1_float))) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_float) begin
            rs2_data = fp_bank_q[rs2_addr];
        end else if (rs2_addr != 5'd0) begin
            rs2_data = int_bank_q[rs2_addr];
        end
        if ((rs2_addr == wb_rd) && ((fp_we && rs2_float) || (int_we && !rs2_float))) begin
            rs2_data = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                int_bank_q[i] <= '0;
                fp_bank_q[i]  <= '0;
            end
        end else if (fp_we) begin
            fp_bank_q[wb_rd] <= wb_data;
        end else if (int_we) begin
            int_bank_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_valid_q <= 1'b0;
            fwd_float_q <= 1'b0;
            fwd_rd_q    <= 5'd0;
            fwd_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            fwd_valid_q <= int_we | fp_we;
            fwd_float_q <= fp_we;
            if (int_we || fp_we) begin
                fwd_rd_q   <= wb_rd;
                fwd_data_q <= wb_data;
                cnt_q      <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_valid  = fwd_valid_q;
    assign fwd_float  = fwd_float_q;
    assign fwd_rd     = fwd_rd_q;
    assign fwd_data   = fwd_data_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed bench for wb_regfile_unit; a second narrow-counter instance exercises wrap-around.
module tb_wb_regfile_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_write, wb_freg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd, rs1_addr, rs2_addr;
    logic        rs1_float, rs2_float;
    logic [31:0] wb_mem_data, wb_alu_result;
    logic [31:0] rs1_data, rs2_data, wb_data, fwd_data;
    logic        fwd_valid, fwd_float;
    logic [4:0]  fwd_rd;
    logic [31:0] commit_cnt;

    logic [31:0] w_rs1_data, w_rs2_data, w_wb_data, w_fwd_data;
    logic        w_fwd_valid, w_fwd_float;
    logic [4:0]  w_fwd_rd;
    logic [3:0]  w_commit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile_unit dut (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write), .wb_freg_write(wb_freg_write),
        .wb_rd(wb_rd), .wb_mem_to_reg(wb_mem_to_reg), .wb_mem_data(wb_mem_data),
        .wb_alu_result(wb_alu_result), .rs1_addr(rs1_addr), .rs1_float(rs1_float),
        .rs2_addr(rs2_addr), .rs2_float(rs2_float), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_float(fwd_float), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .commit_cnt(commit_cnt)
    );

    wb_regfile_unit #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write), .wb_freg_write(wb_freg_write),
        .wb_rd(wb_rd), .wb_mem_to_reg(wb_mem_to_reg), .wb_mem_data(wb_mem_data),
        .wb_alu_result(wb_alu_result), .rs1_addr(rs1_addr), .rs1_float(rs1_float),
        .rs2_addr(rs2_addr), .rs2_float(rs2_float), .rs1_data(w_rs1_data),
        .rs2_data(w_rs2_data), .wb_data(w_wb_data), .fwd_valid(w_fwd_valid),
        .fwd_float(w_fwd_float), .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data),
        .commit_cnt(w_commit_cnt)
    );

    task automatic idle();
        wb_reg_write  = 1'b0;
        wb_freg_write = 1'b0;
        wb_mem_to_reg = 1'b0;
        wb_rd         = 5'd0;
        wb_mem_data   = 32'h0;
        wb_alu_result = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        rs1_addr = 5'd5; rs1_float = 1'b0;
        rs2_addr = 5'd3; rs2_float = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL reset_rs1: got %h want 00000000", rs1_data);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            errors++; $display("FAIL reset_rs2: got %h want 00000000", rs2_data);
        end
        checks++;
        if (fwd_valid !== 1'b0 || fwd_float !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_fwd: got v=%b f=%b rd=%0d d=%h want 0", fwd_valid, fwd_float,
                     fwd_rd, fwd_data);
        end
        checks++;
        if (commit_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", commit_cnt);
        end
    endtask

    task automatic test_int_alu_commit();
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_mem_to_reg = 1'b0;
        wb_alu_result = 32'h1234_5678; wb_mem_data = 32'h0000_AAAA;
        #1;
        checks++;
        if (wb_data !== 32'h1234_5678) begin
            errors++; $display("FAIL alu_wb_data: got %h want 12345678", wb_data);
        end
        step();
        idle();
        rs1_addr = 5'd5; rs1_float = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h1234_5678) begin
            errors++; $display("FAIL x5_read: got %h want 12345678", rs1_data);
        end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_float !== 1'b0 ||
            fwd_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL x5_fwd: got v=%b rd=%0d f=%b d=%h want 1/5/0/12345678", fwd_valid,
                     fwd_rd, fwd_float, fwd_data);
        end
        checks++;
        if (commit_cnt !== 32'd1) begin
            errors++; $display("FAIL x5_cnt: got %0d want 1", commit_cnt);
        end
    endtask

    task automatic test_float_load_bypass();
        wb_freg_write = 1'b1; wb_rd = 5'd3; wb_mem_to_reg = 1'b1;
        wb_mem_data = 32'hDEAD_BEEF; wb_alu_result = 32'h0000_1111;
        rs2_addr = 5'd3; rs2_float = 1'b1;
        rs1_addr = 5'd3; rs1_float = 1'b0;
        #1;
        checks++;
        if (rs2_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL f3_bypass: got %h want deadbeef", rs2_data);
        end
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL x3_untouched: got %h want 00000000", rs1_data);
        end
        step();
        idle();
        #1;
        checks++;
        if (rs2_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL f3_bank: got %h want deadbeef", rs2_data);
        end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_float !== 1'b1 || fwd_rd !== 5'd3 || commit_cnt !== 32'd2)
        begin
            errors++;
            $display("FAIL f3_fwd: got v=%b f=%b rd=%0d cnt=%0d want 1/1/3/2", fwd_valid,
                     fwd_float, fwd_rd, commit_cnt);
        end
    endtask

    task automatic test_x0_drop();
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_alu_result = 32'hFFFF_FFFF;
        rs1_addr = 5'd0; rs1_float = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL x0_no_bypass: got %h want 00000000", rs1_data);
        end
        step();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL x0_read: got %h want 00000000", rs1_data);
        end
        checks++;
        if (fwd_valid !== 1'b0 || commit_cnt !== 32'd2 || fwd_rd !== 5'd3 ||
            fwd_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL x0_fwd_hold: got v=%b cnt=%0d rd=%0d d=%h want 0/2/3/deadbeef",
                     fwd_valid, commit_cnt, fwd_rd, fwd_data);
        end
    endtask

    task automatic test_both_enables();
        wb_reg_write = 1'b1; wb_freg_write = 1'b1; wb_rd = 5'd7;
        wb_alu_result = 32'hA5A5_A5A5;
        rs1_addr = 5'd7; rs1_float = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL both_int_no_bypass: got %h want 00000000", rs1_data);
        end
        step();
        idle();
        rs2_addr = 5'd7; rs2_float = 1'b1;
        #1;
        checks++;
        if (rs2_data !== 32'hA5A5_A5A5 || rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL both_banks: got f7=%h x7=%h want a5a5a5a5/00000000", rs2_data,
                     rs1_data);
        end
        checks++;
        if (fwd_float !== 1'b1 || fwd_valid !== 1'b1 || commit_cnt !== 32'd3) begin
            errors++;
            $display("FAIL both_fwd: got f=%b v=%b cnt=%0d want 1/1/3", fwd_float, fwd_valid,
                     commit_cnt);
        end
    endtask

    task automatic test_back_to_back();
        // Overwrite x5 while reading it (int bypass) and f5 (must not bypass).
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_alu_result = 32'hCAFE_0001;
        rs1_addr = 5'd5; rs1_float = 1'b0;
        rs2_addr = 5'd5; rs2_float = 1'b1;
        #1;
        checks++;
        if (rs1_data !== 32'hCAFE_0001 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL b2b_bypass: got x5=%h f5=%h want cafe0001/00000000", rs1_data,
                     rs2_data);
        end
        step();
        wb_rd = 5'd11; wb_mem_to_reg = 1'b1; wb_mem_data = 32'h0BAD_F00D;
        rs2_addr = 5'd11; rs2_float = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'hCAFE_0001 || rs2_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL b2b_second: got x5=%h x11=%h want cafe0001/0badf00d", rs1_data,
                     rs2_data);
        end
        step();
        idle();
        #1;
        checks++;
        if (fwd_rd !== 5'd11 || fwd_data !== 32'h0BAD_F00D || commit_cnt !== 32'd5) begin
            errors++;
            $display("FAIL b2b_fwd: got rd=%0d d=%h cnt=%0d want 11/0badf00d/5", fwd_rd,
                     fwd_data, commit_cnt);
        end
    endtask

    task automatic test_reset_priority_and_wrap();
        rst = 1'b0;
        wb_reg_write = 1'b1; wb_rd = 5'd9; wb_alu_result = 32'h0000_0055;
        step();
        rst = 1'b1;
        idle();
        rs1_addr = 5'd9; rs1_float = 1'b0;
        rs2_addr = 5'd3; rs2_float = 1'b1;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_prio_regs: got x9=%h f3=%h want 00000000/00000000", rs1_data,
                     rs2_data);
        end
        checks++;
        if (commit_cnt !== 32'd0 || fwd_valid !== 1'b0 || w_commit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_prio_cnt: got cnt=%0d v=%b wcnt=%0d want 0/0/0", commit_cnt,
                     fwd_valid, w_commit_cnt);
        end
        wb_freg_write = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wb_rd = 5'(i);
            wb_alu_result = 32'(i + 100);
            step();
        end
        idle();
        #1;
        checks++;
        if (w_commit_cnt !== 4'hF) begin
            errors++; $display("FAIL wrap_full: got %0d want 15", w_commit_cnt);
        end
        wb_reg_write = 1'b1; wb_rd = 5'd20; wb_alu_result = 32'h1;
        step();
        idle();
        #1;
        checks++;
        if (w_commit_cnt !== 4'h0 || commit_cnt !== 32'd16) begin
            errors++;
            $display("FAIL wrap_zero: got wcnt=%0d cnt=%0d want 0/16", w_commit_cnt, commit_cnt);
        end
    endtask

    initial begin
        idle();
        rst = 1'b0;
        rs1_addr = 5'd0; rs1_float = 1'b0;
        rs2_addr = 5'd0; rs2_float = 1'b0;
        test_reset();
        test_int_alu_commit();
        test_float_load_bypass();
        test_x0_drop();
        test_both_enables();
        test_back_to_back();
        test_reset_priority_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
